// File: rtl/frm_arb_pkg.sv
// frm_arb_pkg: shared widths, beat layout and FSM encoding for the
// frame-source arbiter.
package frm_arb_pkg;

    localparam int NUM_SRC = 4;
    localparam int BEAT_W  = 64;
    localparam int MOD_W   = 3;
    localparam int SRC_W   = 2;

    // Two-state controller: waiting for a packet start, or moving one packet
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [MOD_W-1:0]  mod;
        logic [BEAT_W-1:0] dout;
    } beat_t;

endpackage

// File: rtl/frm_rr_pick.sv
// frm_rr_pick: combinational round-robin picker. The search starts one
// position above the previous winner and wraps, so the previous winner has
// the lowest priority.
module frm_rr_pick
    import frm_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] request,
    input  logic [SRC_W-1:0]   last,
    output logic               valid,
    output logic [SRC_W-1:0]   index
);

    logic [SRC_W-1:0]   w_cand [NUM_SRC];
    logic [NUM_SRC-1:0] w_hit;

    // Candidate k is last+1+k with natural wrap of the index width
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
            assign w_cand[gi] = last + SRC_W'(gi + 1);
            assign w_hit[gi]  = request[w_cand[gi]];
        end
    endgenerate

    assign valid = |request;

    // Nearest requesting candidate wins; scan from far to near so near overrides
    always_comb begin
        index = last;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                index = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/frm_src_arbiter.sv
// frm_src_arbiter: packet-atomic round-robin merge of four frame sources
// into one registered output stream with a one-cycle error flag for a
// start-of-packet seen inside a packet.
// Optional feature macro: FRM_ARB_STATS_EN adds per-source packet counters
// on output pkt_cnt.
module frm_src_arbiter
    import frm_arb_pkg::*;
#(
    parameter int NUM_SRC = frm_arb_pkg::NUM_SRC
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        en_mask,
    input  logic [NUM_SRC-1:0]        in_sop,
    input  logic [NUM_SRC-1:0]        in_eop,
    input  logic [NUM_SRC-1:0]        in_dval,
    input  logic [MOD_W*NUM_SRC-1:0]  in_mod,
    input  logic [BEAT_W*NUM_SRC-1:0] in_dout,
    output logic [NUM_SRC-1:0]        in_ready,
    input  logic                      out_ready,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      out_dval,
    output logic [MOD_W-1:0]          out_mod,
    output logic [BEAT_W-1:0]         out_dout,
    output logic [SRC_W-1:0]          out_src,
    output logic                      err_pulse
`ifdef FRM_ARB_STATS_EN
    ,
    output logic [32*NUM_SRC-1:0]     pkt_cnt
`endif
);

    logic [0:0]       r_state;
    logic [SRC_W-1:0] r_gnt;
    logic [SRC_W-1:0] r_last_gnt;
    logic             r_first;
    beat_t            r_out;
    logic             r_out_dval;
    logic [SRC_W-1:0] r_out_src;
    logic             r_err;

    logic [NUM_SRC-1:0] w_elig;
    logic               w_pick_valid;
    logic [SRC_W-1:0]   w_pick_idx;
    beat_t              w_beat [NUM_SRC];
    beat_t              w_sel;
    logic               w_xfer;
    logic               w_room;
    logic               w_accept;

    // A source may win only when it is enabled and presenting a packet start
    assign w_elig = en_mask & in_dval & in_sop;

    frm_rr_pick u_pick (
        .request (w_elig),
        .last    (r_last_gnt),
        .valid   (w_pick_valid),
        .index   (w_pick_idx)
    );

    // The output register has room when it is empty or draining this cycle
    assign w_xfer = (r_state == ST_XFER);
    assign w_room = out_ready | ~r_out_dval;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_beat[gi]   = {in_sop[gi], in_eop[gi],
                                   in_mod[MOD_W*gi +: MOD_W],
                                   in_dout[BEAT_W*gi +: BEAT_W]};
            // Ready never looks at in_dval, so sources may wait on it safely
            assign in_ready[gi] = w_xfer & w_room & (r_gnt == SRC_W'(gi));
        end
    endgenerate

    assign w_sel    = w_beat[r_gnt];
    assign w_accept = w_xfer & w_room & in_dval[r_gnt];

    // Arbitration FSM: grant is taken in IDLE and held until the eop beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_last_gnt <= SRC_W'(NUM_SRC - 1);
            r_first    <= 1'b1;
        end else if (r_state == ST_IDLE) begin
            if (w_pick_valid) begin
                r_gnt   <= w_pick_idx;
                r_first <= 1'b1;
                r_state <= ST_XFER;
            end
        end else if (w_accept) begin
            r_first <= 1'b0;
            if (w_sel.eop) begin
                r_last_gnt <= r_gnt;
                r_state    <= ST_IDLE;
            end
        end
    end

    // Output register: load on accept, drop valid once consumed, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_out_dval <= 1'b0;
            r_out_src  <= '0;
            r_err      <= 1'b0;
        end else begin
            // A sop after the packet's first beat is flagged but still forwarded
            r_err <= w_accept & w_sel.sop & ~r_first;
            if (w_accept) begin
                r_out      <= w_sel;
                r_out_dval <= 1'b1;
                r_out_src  <= r_gnt;
            end else if (r_out_dval && out_ready) begin
                r_out_dval <= 1'b0;
            end
        end
    end

    assign out_sop   = r_out.sop;
    assign out_eop   = r_out.eop;
    assign out_mod   = r_out.mod;
    assign out_dout  = r_out.dout;
    assign out_dval  = r_out_dval;
    assign out_src   = r_out_src;
    assign err_pulse = r_err;

`ifdef FRM_ARB_STATS_EN
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
            logic [31:0] r_pkt_cnt;
            // Count completed packets of this source, wrapping naturally
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pkt_cnt <= '0;
                end else if (w_accept && w_sel.eop && (r_gnt == SRC_W'(gi))) begin
                    r_pkt_cnt <= r_pkt_cnt + 32'd1;
                end
            end
            assign pkt_cnt[32*gi +: 32] = r_pkt_cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_frm_src_arbiter.sv
// tb_frm_src_arbiter: directed and randomized packet traffic against a
// transaction-level model: whole packets queued per source, expected output
// order computed by round-robin over sources that still hold packets.
`timescale 1ns/1ps
module tb_frm_src_arbiter;

    typedef struct packed {
        logic        first;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic [63:0] data;
    } tb_beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   en_mask;
    logic [3:0]   in_sop, in_eop, in_dval;
    logic [11:0]  in_mod;
    logic [255:0] in_dout;
    logic [3:0]   in_ready;
    logic         out_ready;
    logic         out_sop, out_eop, out_dval;
    logic [2:0]   out_mod;
    logic [63:0]  out_dout;
    logic [1:0]   out_src;
    logic         err_pulse;
`ifdef FRM_ARB_STATS_EN
    logic [127:0] pkt_cnt;
`endif

    frm_src_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .en_mask   (en_mask),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_dval   (in_dval),
        .in_mod    (in_mod),
        .in_dout   (in_dout),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_dval  (out_dval),
        .out_mod   (out_mod),
        .out_dout  (out_dout),
        .out_src   (out_src),
`ifdef FRM_ARB_STATS_EN
        .pkt_cnt   (pkt_cnt),
`endif
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Model state
    tb_beat_t    src_q [4][$];
    logic [70:0] exp_q [$];
    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ordy_mode = 0;
    bit          gap_en = 0;
    int          model_last = 3;
    logic [31:0] cnt_model [4];
    logic [3:0]  prev_sx = 4'b0;
    tb_beat_t    prev_beat;
    int          prev_src = 0;
    bit          prev_rst = 1'b0;
    bit          prev_hold = 1'b0;
    bit          prev_err_exp = 1'b0;
    logic [71:0] prev_out = '0;
    bit          chk_gap2 = 1'b0;
    int          last_out_cyc = -1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int len, input logic [2:0] lmod, input int bad_sop_at);
        tb_beat_t b;
        for (int j = 0; j < len; j++) begin
            b.first = (j == 0);
            b.sop   = (j == 0) || (j == bad_sop_at);
            b.eop   = (j == len - 1);
            b.mod   = (j == len - 1) ? lmod : 3'($urandom_range(0, 7));
            b.data  = {$urandom(), $urandom()};
            src_q[s].push_back(b);
        end
    endtask

    // Expected output order: repeatedly take the next enabled source after
    // the previous winner that still holds a packet, emit that whole packet.
    task automatic plan();
        int       rem_pos [4];
        int       pick;
        bit       found;
        tb_beat_t b;
        for (int i = 0; i < 4; i++) rem_pos[i] = 0;
        while (1) begin
            found = 0;
            pick  = 0;
            for (int k = 1; k <= 4; k++) begin
                int s;
                s = (model_last + k) % 4;
                if (!found && en_mask[s] && rem_pos[s] < src_q[s].size()) begin
                    found = 1;
                    pick  = s;
                end
            end
            if (!found) break;
            do begin
                b = src_q[pick][rem_pos[pick]];
                exp_q.push_back({2'(pick), b.sop, b.eop, b.mod, b.data});
                rem_pos[pick]++;
            end while (!b.eop);
            model_last = pick;
        end
    endtask

    task automatic drive();
        tb_beat_t b;
        in_sop  = '0;
        in_eop  = '0;
        in_dval = '0;
        in_mod  = '0;
        in_dout = '0;
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                in_dval[i] = b.first ? 1'b1 : (gap_en ? ($urandom_range(0, 3) != 0) : 1'b1);
                in_sop[i]  = b.sop;
                in_eop[i]  = b.eop;
                in_mod[3*i +: 3]   = b.mod;
                in_dout[64*i +: 64] = b.data;
            end
        end
        case (ordy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    endtask

    // One clock: check at negedge, advance sources after the edge, redrive
    task automatic step();
        logic [3:0]  sx;
        logic [71:0] cur_out;
        logic [70:0] e;
        @(negedge clk);
        cur_out = {out_dval, out_src, out_sop, out_eop, out_mod, out_dout};
        if (prev_rst) begin
            chk("reset_state", {cur_out, err_pulse, in_ready}, '0);
        end else begin
            chk("err_pulse", err_pulse, prev_err_exp);
            if (prev_sx != 4'b0)
                chk("latency_beat", cur_out, {1'b1, 2'(prev_src), prev_beat.sop, prev_beat.eop,
                                              prev_beat.mod, prev_beat.data});
            else if (prev_hold)
                chk("hold_stable", cur_out, prev_out);
            if (out_dval && !out_ready)
                chk("ready_blocked", in_ready, 4'b0);
            chk("ready_onehot", ($countones(in_ready) <= 1), 1'b1);
        end
`ifdef FRM_ARB_STATS_EN
        chk("pkt_cnt", pkt_cnt, {cnt_model[3], cnt_model[2], cnt_model[1], cnt_model[0]});
`endif
        if (!rst && out_dval && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", cur_out[70:0], e);
                $display("cyc %0d: out src=%0d sop=%0b eop=%0b mod=%0d dout=%h", cyc,
                         out_src, out_sop, out_eop, out_mod, out_dout);
                if (chk_gap2 && last_out_cyc >= 0)
                    chk("pkt_gap", cyc - last_out_cyc, 2);
                last_out_cyc = cyc;
            end
        end
        sx        = rst ? 4'b0 : (in_dval & in_ready);
        prev_hold = !rst && out_dval && !out_ready;
        prev_out  = cur_out;
        @(posedge clk);
        cyc++;
        #1;
        prev_rst     = rst;
        prev_sx      = sx;
        prev_err_exp = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                src_q[i].delete();
                cnt_model[i] = '0;
            end
            exp_q.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sx[i]) begin
                    prev_beat    = src_q[i][0];
                    prev_src     = i;
                    prev_err_exp = prev_beat.sop && !prev_beat.first;
                    if (prev_beat.eop) cnt_model[i] = cnt_model[i] + 32'd1;
                    void'(src_q[i].pop_front());
                end
            end
        end
        drive();
    endtask

    function automatic bit busy();
        bit r;
        r = 0;
        for (int i = 0; i < 4; i++)
            if (en_mask[i] && src_q[i].size() > 0) r = 1;
        return r;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy()) && n < budget) begin
            step();
            n++;
        end
        chk(tag, exp_q.size(), 0);
        step();
        step();
    endtask

    task automatic flush_disabled();
        for (int i = 0; i < 4; i++)
            if (!en_mask[i]) src_q[i].delete();
        drive();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) cnt_model[i] = '0;
        rst     = 1'b1;
        en_mask = 4'b1111;
        drive();
        repeat (3) @(posedge clk);
        #1;
        prev_rst = 1'b1;
        rst      = 1'b0;
        drive();

        // Single-beat packets from every source: order 0,1,2,3,0, 2 cycles each
        add_pkt(0, 1, 3'd1, -1);
        add_pkt(1, 1, 3'd2, -1);
        add_pkt(2, 1, 3'd3, -1);
        add_pkt(3, 1, 3'd4, -1);
        add_pkt(0, 1, 3'd0, -1);
        plan();
        drive();
        chk_gap2     = 1'b1;
        last_out_cyc = -1;
        drain("drain_single", 40);
        chk_gap2 = 1'b0;

        // Source 2 sends 3 beats (mod 5 last) while source 1 waits
        add_pkt(1, 1, 3'd7, -1);
        plan();
        drive();
        drain("drain_prep", 20);
        add_pkt(2, 3, 3'd5, -1);
        add_pkt(1, 2, 3'd6, -1);
        plan();
        drive();
        drain("drain_multi", 40);

        // Back-pressure held for 4 cycles mid-packet
        add_pkt(3, 5, 3'd2, -1);
        plan();
        drive();
        step();
        step();
        step();
        ordy_mode = 2;
        drive();
        repeat (4) step();
        ordy_mode = 0;
        drive();
        drain("drain_hold", 40);

        // Only sources 1 and 3 enabled while all four request
        en_mask = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            add_pkt(i, $urandom_range(1, 3), 3'($urandom_range(0, 7)), -1);
            add_pkt(i, $urandom_range(1, 3), 3'($urandom_range(0, 7)), -1);
        end
        plan();
        drive();
        drain("drain_mask", 80);
        flush_disabled();
        en_mask = 4'b1111;

        // sop repeated on the second beat of a packet
        add_pkt(0, 3, 3'd1, 1);
        plan();
        drive();
        drain("drain_badsop", 30);

        // Randomized rounds: random mask, gaps and back-pressure
        for (int r = 0; r < 4; r++) begin
            en_mask   = 4'($urandom_range(1, 15));
            gap_en    = 1'b1;
            ordy_mode = 1;
            for (int i = 0; i < 4; i++)
                if (en_mask[i])
                    for (int p = 0; p < 3; p++)
                        add_pkt(i, $urandom_range(1, 4), 3'($urandom_range(0, 7)), -1);
            plan();
            drive();
            drain("drain_random", 2000);
        end
        gap_en    = 1'b0;
        ordy_mode = 0;
        en_mask   = 4'b1111;
        drive();

        // Reset on the second beat of a 5-beat packet
        add_pkt(1, 5, 3'd3, -1);
        plan();
        drive();
        n = 0;
        while (src_q[1].size() != 3 && n < 20) begin
            step();
            n++;
        end
        chk("rst_setup", src_q[1].size(), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_last = 3;
        add_pkt(1, 1, 3'd2, -1);
        add_pkt(0, 1, 3'd6, -1);
        plan();
        drive();
        drain("drain_after_rst", 30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frm_src_arbiter.md
FRM_SRC_ARBITER -- requirements
Module: frm_src_arbiter

Interface
REQ-001 Parameter: NUM_SRC, default 4, number of frame sources; fixed at 4 in this release.
REQ-002 Port: clk  input  1  single clock for all logic.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: en_mask  input  4  per-source enable; bit i=0 excludes source i from arbitration.
REQ-005 Port: in_sop  input  4  per-source start-of-packet.
REQ-006 Port: in_eop  input  4  per-source end-of-packet.
REQ-007 Port: in_dval  input  4  per-source beat valid.
REQ-008 Port: in_mod  input  12  per-source 3-bit mod, source i at [3i+2:3i]; 0 = all 8 bytes valid.
REQ-009 Port: in_dout  input  256  per-source 64-bit beat, source i at [64i+63:64i].
REQ-010 Port: in_ready  output  4  per-source accept; a beat transfers when in_dval[i] and in_ready[i] are both high.
REQ-011 Port: out_ready  input  1  downstream accept.
REQ-012 Port: out_sop, out_eop, out_dval  output  1 each  merged stream control.
REQ-013 Port: out_mod  output  3; out_dout  output  64  merged stream data.
REQ-014 Port: out_src  output  2  index of the source owning the current output beat.
REQ-015 Port: err_pulse  output  1  one-cycle protocol-error flag.

Function
REQ-016 FSM states: IDLE and XFER; grant is packet-atomic and changes only in IDLE.
REQ-017 Eligible(i) = en_mask[i] & in_dval[i] & in_sop[i].
REQ-018 IDLE: if any source is eligible, select one round-robin, starting at last_gnt+1 mod 4 and searching upward with wrap; latch it into gnt, then enter XFER on the next cycle.
REQ-019 IDLE with no eligible source: remain in IDLE; in_ready = 0.
REQ-020 XFER: in_ready[gnt] = out_ready | ~out_dval; all other in_ready bits = 0.
REQ-021 Output register: on an accepted beat, load sop/eop/mod/dout from source gnt, set out_dval=1 and out_src=gnt; latency is 1 cycle from acceptance.
REQ-022 Output register: when out_dval & out_ready and no new beat is accepted, clear out_dval; when out_dval & ~out_ready, hold every output stable.
REQ-023 XFER, accepted beat with eop=1: last_gnt <= gnt and next state is IDLE; minimum gap between packets is 1 arbitration cycle.
REQ-024 XFER, accepted beat with sop=1 after the first beat: pulse err_pulse for 1 cycle and forward the beat unchanged.
REQ-025 A single-beat packet (sop & eop together) is accepted and returns to IDLE the next cycle.
REQ-026 Clearing en_mask[gnt] mid-packet does not abort the packet; the mask applies only at the next arbitration.
REQ-027 in_ready depends combinationally only on state, gnt, out_dval and out_ready, never on in_dval.

Reset
REQ-028 While rst=1 on a clk edge: state=IDLE, gnt=0, last_gnt=3 (source 0 wins first), out_* = 0, err_pulse=0, in_ready=0.
REQ-029 Reset mid-packet discards the partial packet; no eop is generated for it.

Configuration
REQ-030 Macro FRM_ARB_STATS_EN defined: add output pkt_cnt (128 bits, 32 bits per source at [32i+31:32i]), incremented on each accepted eop beat of that source, wrapping at 2^32, cleared by rst.
REQ-031 Macro FRM_ARB_STATS_EN undefined: the pkt_cnt port and counters are absent; all other behaviour is identical.

Structure
REQ-032 Package frm_arb_pkg holds NUM_SRC, the beat/mod/source-index widths and the IDLE/XFER state encoding.
REQ-033 Sub-module frm_rr_pick: combinational round-robin picker (request[3:0], last[1:0] -> valid, index[1:0]), instantiated once.

Verification
REQ-034 All four sources hold single-beat packets, out_ready=1 -> out_src sequence 0,1,2,3,0; each beat appears 1 cycle after acceptance; 2 cycles per packet.
REQ-035 Source 2 sends 3 beats (mod=5 on the eop beat) while source 1 requests -> all 3 beats from source 2 are contiguous, out_mod=5 on the last, then source 1 is granted.
REQ-036 out_ready held low for 4 cycles mid-packet -> outputs stable, in_ready[gnt]=0 after the held beat, no beats lost or duplicated.
REQ-037 en_mask=4'b1010, all sources request -> only sources 1 and 3 are granted, alternating.
REQ-038 sop reasserted on the 2nd beat of a packet -> err_pulse=1 for exactly 1 cycle, beat forwarded unchanged.
REQ-039 rst asserted on the 2nd beat of a 5-beat packet -> next cycle all outputs are 0 and the FSM is in IDLE; the first grant after reset goes to source 0; with FRM_ARB_STATS_EN, pkt_cnt=0.
